// File: rtl/sprite_ram_bank.sv
// Multi-slot sprite pixel store: per-slot RAMs, 2-stage read pipeline with transparency flag,
// fill engine with write-port priority. Define SPRITE_MIRROR_EN to add the horizontal mirror input.
module sprite_ram_slot #(
  parameter int DW = 12,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];

  // Read-first: q samples the old word when read and write hit the same address.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

module sprite_ram_bank #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 10,
  parameter int COL_BITS    = 5,
  parameter int NUM_SPRITES = 4,
  parameter logic [DATA_WIDTH-1:0] TRANSP_KEY = '0,
  parameter int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [SEL_W-1:0]      wr_sel,
  input  logic [ADDR_WIDTH-1:0] addr_w,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  input  logic [SEL_W-1:0]      rd_sel,
  input  logic [ADDR_WIDTH-1:0] addr_r,
`ifdef SPRITE_MIRROR_EN
  input  logic                  mirror,
`endif
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  transparent,
  input  logic                  fill_start,
  input  logic [SEL_W-1:0]      fill_sel,
  input  logic [DATA_WIDTH-1:0] fill_color,
  output logic                  busy,
  output logic                  fill_done
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  localparam logic [SEL_W:0]        NSPR = (SEL_W+1)'(NUM_SPRITES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_st_t;

  fill_st_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [SEL_W-1:0]        fsel_q;
  logic [DATA_WIDTH-1:0]   fcol_q;
  logic                    fill_we;

  // ---------------- fill FSM ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fill_start) state_d = S_FILL;
      S_FILL:  if (cnt == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_FILL);
    fill_done = (state_q == S_DONE);
    fill_we   = (state_q == S_FILL);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      fsel_q <= '0;
      fcol_q <= '0;
    end else if (state_q == S_IDLE && fill_start) begin
      cnt    <= '0;
      fsel_q <= fill_sel;
      fcol_q <= fill_color;
    end else if (state_q == S_FILL) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // ---------------- write port: fill beats host ----------------
  logic                  w_en;
  logic [SEL_W-1:0]      w_sel;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  always_comb begin
    w_en   = fill_we | we;
    w_sel  = fill_we ? fsel_q : wr_sel;
    w_addr = fill_we ? cnt    : addr_w;
    w_data = fill_we ? fcol_q : din;
  end

  // ---------------- read address ----------------
  logic [ADDR_WIDTH-1:0] raddr_eff;
`ifdef SPRITE_MIRROR_EN
  assign raddr_eff = mirror ? {addr_r[ADDR_WIDTH-1:COL_BITS], ~addr_r[COL_BITS-1:0]} : addr_r;
`else
  assign raddr_eff = addr_r;
`endif

  // ---------------- slot array ----------------
  logic [NUM_SPRITES-1:0][DATA_WIDTH-1:0] bank_q;

  // An out-of-range select matches no slot, so such writes fall on the floor.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
    sprite_ram_slot #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_slot (
      .clk   (clk),
      .we    (w_en && (w_sel == SEL_W'(g))),
      .waddr (w_addr),
      .wdata (w_data),
      .raddr (raddr_eff),
      .q     (bank_q[g])
    );
  end

  // ---------------- read pipeline ----------------
  logic [2:1]            vld_pipe;
  logic [SEL_W-1:0]      sel1;
  logic                  inr1;
  logic [DATA_WIDTH-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      sel1     <= '0;
      inr1     <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_en};
      sel1     <= rd_sel;
      inr1     <= ({1'b0, rd_sel} < NSPR);
    end
  end

  assign rd_word = inr1 ? bank_q[sel1] : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dout        <= '0;
      transparent <= 1'b0;
    end else begin
      if (vld_pipe[1]) dout <= rd_word;
      transparent <= vld_pipe[1] && (rd_word == TRANSP_KEY);
    end
  end

  assign rd_valid = vld_pipe[2];
endmodule
